// File: rtl/reservation_station.sv
// Collapsing reservation station: buffers decoded instructions, snoops the CDB, issues oldest ready entry.
// Latency: allocate or wakeup -> issuable next cycle; select is combinational from registered state.
// Backpressure: in_ready drops when full (registered state only); issue waits on issue_ready.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int IW    = 116,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [IW-1:0]   in_inst,
  output logic            in_ready,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [31:0]     cdb_data,
  output logic            issue_valid,
  output logic [IW-1:0]   issue_inst,
  input  logic            issue_ready,
  output logic [3:0]      occupancy
);

  localparam int         MDW     = IW - 85;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  // Applies a CDB broadcast to one instruction; a woken store operand also becomes the store data.
  function automatic logic [IW-1:0] wake(input logic [IW-1:0] e, input logic hit_en,
                                         input logic [TAGW-1:0] tag, input logic [31:0] data);
    logic [IW-1:0] r;
    r = e;
    if (hit_en && !e[5] && e[6 +: TAGW] == tag) begin
      r[37:6] = data;
      r[5]    = 1'b1;
    end
    if (hit_en && !e[38] && e[39 +: TAGW] == tag) begin
      r[70:39] = data;
      r[38]    = 1'b1;
      if (e[77]) r[IW-1:85] = data[MDW-1:0];
    end
    return r;
  endfunction

  logic [IW-1:0]    ent [DEPTH];
  logic [IW-1:0]    wk  [DEPTH];
  logic [IW-1:0]    nxt [DEPTH];
  logic [3:0]       occ;
  logic [3:0]       sel;
  logic [3:0]       aidx;
  logic [3:0]       occ_n;
  logic [DEPTH-1:0] rdy;
  logic             do_iss;
  logic             do_alloc;

  assign occupancy = occ;
  assign in_ready  = occ < DEPTH_C;
  assign do_iss    = issue_valid & issue_ready;
  assign do_alloc  = in_valid & in_ready;

  // Scan from the top so the lowest (oldest) ready slot wins.
  always_comb begin
    sel         = '0;
    rdy         = '0;
    issue_inst  = ent[0];
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = (4'(i) < occ) && ent[i][5] && ent[i][38];
      if (rdy[i]) begin
        sel        = 4'(i);
        issue_inst = ent[i];
      end
    end
    issue_valid = |rdy;
  end

  always_comb begin
    aidx  = occ - {3'b000, do_iss};
    occ_n = occ + {3'b000, do_alloc} - {3'b000, do_iss};
    for (int i = 0; i < DEPTH; i++) begin
      wk[i]  = wake(ent[i], cdb_valid, cdb_tag, cdb_data);
      nxt[i] = wk[i];
    end
    if (do_iss) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (4'(i) >= sel) nxt[i] = wk[i+1];
      end
    end
    // The new entry lands after the collapse, so it is always the youngest.
    if (do_alloc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (4'(i) == aidx) nxt[i] = wake(in_inst, cdb_valid, cdb_tag, cdb_data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      occ <= occ_n;
      for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
    end
  end

endmodule
